fetch_arbiter: RTL and testbench
================================

Name: fetch_arbiter

Overview:
Front end of the pipelined core. It owns the single shared memory port, prefetches instructions into a small queue that feeds the IF/ID register, and arbitrates load/store accesses from the MEM stage, with data taking priority over fetch. Branch and jump redirects from the datapath flush the queue and restart fetch at the new PC. Stale fetch responses are dropped using an epoch bit.

Parameters:
DEPTH, 4, prefetch queue entries (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
redirect  in  1  flush queue and restart fetch this cycle
redirect_pc  in  32  new fetch PC; bits [1:0] forced to 00
inst_valid  out  1  queue head valid
inst_ready  in  1  decode accepts head (pop on valid&&ready)
inst_out  out  32  head instruction; 32'h0000_0033 (NOP) when empty
inst_pc  out  32  head PC; 0 when empty
d_req  in  1  data access request, held until d_done
d_we  in  1  1=store, 0=load
d_addr  in  32  data byte address
d_func  in  3  funct3 size/sign code, passed through
d_wdata  in  32  store data
d_rdata  out  32  load data, held until next data response
d_done  out  1  one-cycle pulse when the data access completes
mem_en  out  1  memory access this cycle
mem_we  out  1  memory write enable
mem_addr  out  32  memory address
mem_func  out  3  memory funct3
mem_wdata  out  32  memory write data
mem_rdata  in  32  read data, valid the cycle after issue

Behaviour:
- Memory timing: access issued in cycle N (mem_* driven combinationally from registered state and d_req); mem_rdata valid in N+1. At most one issue per cycle. Issues may be back-to-back.
- In-flight register: kind (NONE/FETCH/DATA), fetch PC, epoch. Updated every cycle with this cycle's issue.
- Arbitration each cycle, in priority order:
  - Data issue if d_req=1 and no DATA is in flight: mem_addr=d_addr, mem_func=d_func, mem_we=d_we, mem_wdata=d_wdata.
  - Otherwise fetch issue if count + (in-flight FETCH ? 1 : 0) < DEPTH and redirect=0: mem_addr=fetch_pc, mem_func=3'b010, mem_we=0. Then fetch_pc += 4, wrapping mod 2^32.
  - Otherwise mem_en=0.
- Data response (in-flight DATA): d_done=1 for one cycle. For loads, d_rdata<=mem_rdata. For stores, d_rdata is unchanged. The requester must treat d_req still high in the cycle after d_done as a new request.
- Fetch response (in-flight FETCH): push {pc, mem_rdata} into the queue only if its epoch equals the current epoch and redirect=0. Otherwise discard.
- Queue: count 0..DEPTH, circular pointers wrap mod DEPTH. inst_valid = (count != 0). Push and pop in the same cycle leaves count unchanged. Push when full cannot occur because of the credit check; an assertion must flag it.
- Redirect cycle:
  - Queue is cleared (count=0).
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - Epoch toggles.
  - No fetch is issued.
  - Redirect takes precedence over a simultaneous pop or push.
  - inst_valid=0 in the following cycle.
  - A data access in flight is unaffected.
- Latency: reset deasserted at cycle 0 → first fetch issued cycle 0 → inst_valid=1 with inst_pc=RESET_PC in cycle 1. After a redirect at cycle R, the earliest new instruction is valid at R+2.
- Reset (synchronous, overrides everything, including mid-access):
  - Values: count=0, in-flight=NONE, epoch=0, fetch_pc=RESET_PC, d_rdata=0, d_done=0, inst_valid=0.
  - mem_en=0 and mem_we=0 while rst=1.
  - Responses to accesses issued before reset are ignored.

Decomposition:
- Shared constants in defines package: FUNC_WORD=3'b010, NOP_INST=32'h0000_0033, in-flight kind encodings KIND_NONE/KIND_FETCH/KIND_DATA.
- One sub-module, prefetch_fifo, parameterised by DEPTH and width 64: push, pop, flush, count, head outputs.
- Arbitration, in-flight tracking and epoch logic stay in fetch_arbiter.

Test Plan:
1. Reset, then release; memory word at addr A = A; inst_ready=1 → inst_valid from cycle 1, inst_pc 0,4,8,12 on consecutive cycles, inst_out equal to inst_pc.
2. inst_ready=0 after reset → exactly 4 fetches issued (0..12), then mem_en=0 while full. Raise inst_ready → one pop per cycle, fetch resumes at 16, no gap or duplicate PC.
3. While streaming, d_req load at 0x40 with mem[0x40]=0xDEADBEEF → that cycle mem_addr=0x40, mem_we=0. Next cycle d_done=1, d_rdata=0xDEADBEEF. Instruction PC sequence is uninterrupted apart from the one-cycle bubble.
4. redirect with redirect_pc=0x103 while a fetch of 0x10 is in flight → 0x10 response discarded, next fetch at 0x100, first valid inst_pc=0x100 two cycles after redirect.
5. Store d_we=1, d_func=000, d_addr=0x20, d_wdata=0xAB → mem_we=1, mem_func=000, d_done pulses, d_rdata unchanged. A following load at 0x20 returns low byte 0xAB.
6. rst pulsed for one cycle with queue full and DATA in flight → next cycle inst_valid=0, d_done=0, d_rdata=0, first fetch at RESET_PC, stale response ignored.

Source files
------------

// File: rtl/fetch_arbiter_pkg.sv
// Shared encodings for the fetch/data front end: memory size code, NOP filler,
// in-flight access kinds and the prefetch queue entry layout.
package fetch_arbiter_pkg;

    localparam logic [2:0]  FUNC_WORD = 3'b010;
    localparam logic [31:0] NOP_INST  = 32'h0000_0033;

    typedef enum logic [1:0] {
        KIND_NONE  = 2'd0,
        KIND_FETCH = 2'd1,
        KIND_DATA  = 2'd2
    } kind_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } qent_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Circular prefetch queue with fall-through: a push into an empty queue is visible at the
// head the same cycle. Flush beats push/pop; the owner must never push when full.
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           din_i,
    output logic                   valid_o,
    output logic [W-1:0]           head_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] count_q, count_d;
    logic          empty, pop_en;

    assign empty   = (count_q == '0);
    assign valid_o = !empty || push_i;
    assign head_o  = empty ? din_i : mem_q[rd_q];
    assign pop_en  = pop_i && valid_o;
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_en)
            count_d = count_q + CW'(1);
        else if (!push_i && pop_en)
            count_d = count_q - CW'(1);
    end

    // Pass-through (empty, push and pop together) advances both pointers, count stays put.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i)
                wr_q <= wr_q + AW'(1);
            if (pop_en)
                rd_q <= rd_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i)
            mem_q[wr_q] <= din_i;
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !pop_en && !flush_i && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/fetch_arbiter.sv
// Single memory port shared by instruction prefetch and MEM-stage loads/stores (data wins);
// responses arrive one cycle after issue, fetch stalls on queue credit, stale fetches die by epoch.
module fetch_arbiter
    import fetch_arbiter_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_func,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_func,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(DEPTH) + 1;

    kind_t         kind_q, kind_d;
    logic          ld_q;
    logic          ep_q, epoch_q;
    logic [31:0]   ipc_q, fetch_pc_q, rdata_q;
    logic [CW-1:0] count, credit;
    logic          data_issue, fetch_issue, data_rsp, fetch_push, head_vld;
    logic [31:0]   redir_pc;
    qent_t         push_ent, head_ent;

    assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

    // A fetch already in flight has a reserved slot, so the queue can never overflow.
    assign credit      = count + ((kind_q == KIND_FETCH) ? CW'(1) : CW'(0));
    assign data_issue  = !rst && d_req && (kind_q != KIND_DATA);
    assign fetch_issue = !rst && !data_issue && !redirect && (credit < CW'(DEPTH));
    assign data_rsp    = !rst && (kind_q == KIND_DATA);
    assign fetch_push  = !rst && !redirect && (kind_q == KIND_FETCH) && (ep_q == epoch_q);

    always_comb begin
        mem_en    = data_issue || fetch_issue;
        mem_we    = data_issue && d_we;
        mem_addr  = fetch_pc_q;
        mem_func  = FUNC_WORD;
        mem_wdata = '0;
        kind_d    = KIND_NONE;
        if (data_issue) begin
            mem_addr  = d_addr;
            mem_func  = d_func;
            mem_wdata = d_wdata;
            kind_d    = KIND_DATA;
        end else if (fetch_issue) begin
            kind_d    = KIND_FETCH;
        end
    end

    assign d_done  = data_rsp;
    assign d_rdata = (data_rsp && ld_q) ? mem_rdata : rdata_q;

    assign push_ent = '{pc: ipc_q, inst: mem_rdata};

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .W     (64)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (fetch_push),
        .pop_i   (inst_ready),
        .din_i   (push_ent),
        .valid_o (head_vld),
        .head_o  (head_ent),
        .count_o (count)
    );

    assign inst_valid = head_vld && !rst;
    assign inst_out   = inst_valid ? head_ent.inst : NOP_INST;
    assign inst_pc    = inst_valid ? head_ent.pc : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            kind_q     <= KIND_NONE;
            ld_q       <= 1'b0;
            ep_q       <= 1'b0;
            ipc_q      <= 32'h0;
            epoch_q    <= 1'b0;
            fetch_pc_q <= RESET_PC;
            rdata_q    <= 32'h0;
        end else begin
            kind_q <= kind_d;
            ld_q   <= data_issue && !d_we;
            ep_q   <= epoch_q;
            ipc_q  <= fetch_pc_q;
            if (redirect) begin
                fetch_pc_q <= redir_pc;
                epoch_q    <= ~epoch_q;
            end else if (fetch_issue) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            if (data_rsp && ld_q)
                rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed bench for fetch_arbiter: a word-per-address memory model, expected instruction
// and load-data queues filled by the stimulus and drained by an independent monitor.
module tb_fetch_arbiter;

    logic        clk = 1'b0;
    logic        rst, redirect, inst_ready, d_req, d_we;
    logic [31:0] redirect_pc, d_addr, d_wdata;
    logic [2:0]  d_func;
    logic        inst_valid, d_done, mem_en, mem_we;
    logic [31:0] inst_out, inst_pc, d_rdata, mem_addr, mem_wdata;
    logic [2:0]  mem_func;
    logic [31:0] mem_rdata = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] inst_exp [$];
    logic [31:0] data_exp [$];
    logic [31:0] mon_e;

    logic [31:0] ovr [logic [31:0]];
    logic [31:0] wr_word;

    fetch_arbiter #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_func(d_func), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_func(mem_func),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Unwritten words read back as their own word address.
    function automatic logic [31:0] rdw(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (ovr.exists(w))
            return ovr[w];
        return w;
    endfunction

    always @(posedge clk) begin
        if (mem_en && !mem_we)
            mem_rdata <= rdw(mem_addr);
        if (mem_en && mem_we) begin
            wr_word = rdw(mem_addr);
            case (mem_func[1:0])
                2'b00:   wr_word[8*mem_addr[1:0] +: 8] = mem_wdata[7:0];
                2'b01:   wr_word[16*mem_addr[1] +: 16] = mem_wdata[15:0];
                default: wr_word = mem_wdata;
            endcase
            ovr[{mem_addr[31:2], 2'b00}] = wr_word;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (inst_valid && inst_ready) begin
                if (inst_exp.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL inst_unexpected: got pc %h, none expected", inst_pc);
                end else begin
                    mon_e = inst_exp.pop_front();
                    chk("inst_pc", inst_pc, mon_e);
                    chk("inst_out", inst_out, mon_e);
                end
            end
            if (d_done) begin
                if (data_exp.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL d_done_unexpected: got rdata %h, none expected", d_rdata);
                end else begin
                    mon_e = data_exp.pop_front();
                    chk("d_rdata", d_rdata, mon_e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic dacc(input logic we, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd);
        data_exp.push_back(exp_rd);
        cyc();
        d_req = 1'b1; d_we = we; d_func = f; d_addr = a; d_wdata = wd;
        mid();
        chk("d_issue_en", mem_en, 1);
        chk("d_issue_addr", mem_addr, a);
        chk("d_issue_we", mem_we, we);
        chk("d_issue_func", mem_func, f);
        if (we)
            chk("d_issue_wdata", mem_wdata, wd);
        cyc();
        mid();
        chk("d_done_pulse", d_done, 1);
        cyc();
        d_req = 1'b0; d_we = 1'b0;
    endtask

    initial begin
        int nf;
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_func = 3'b010; d_wdata = 32'h0;
        ovr[32'h40] = 32'hDEAD_BEEF;

        // Reset state, then streaming from RESET_PC with decode always ready.
        for (int i = 0; i < 3; i++) begin
            cyc(); mid();
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_inst_valid", inst_valid, 0);
            chk("rst_d_done", d_done, 0);
            chk("rst_d_rdata", d_rdata, 0);
        end
        for (int k = 0; k < 4; k++) inst_exp.push_back(32'(4 * k));
        cyc(); rst = 1'b0; mid();
        chk("p1_first_fetch_en", mem_en, 1);
        chk("p1_first_fetch_addr", mem_addr, 32'h0);
        chk("p1_c0_valid", inst_valid, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc(); mid();
            chk("p1_valid", inst_valid, 1);
            chk("p1_pc", inst_pc, 32'(4 * (k - 1)));
        end
        cyc(); inst_ready = 1'b0;

        // Decode stalled: exactly DEPTH fetches, then resume without gaps.
        cyc(); rst = 1'b1; mid();
        cyc(); rst = 1'b0; nf = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) cyc();
            mid();
            if (mem_en) begin
                chk("p2_fetch_addr", mem_addr, 32'(nf * 4));
                nf++;
            end
        end
        chk("p2_fetch_count", nf, 4);
        chk("p2_full_head_pc", inst_pc, 32'h0);
        for (int k = 0; k < 8; k++) inst_exp.push_back(32'(4 * k));
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (k == 0) inst_ready = 1'b1;
            mid();
            chk("p2_stream_valid", inst_valid, 1);
            chk("p2_stream_pc", inst_pc, 32'(4 * k));
        end
        cyc(); inst_ready = 1'b0;

        // Load while streaming costs one fetch bubble.
        cyc(); rst = 1'b1; mid();
        cyc(); rst = 1'b0; inst_ready = 1'b1;
        for (int k = 0; k < 6; k++) inst_exp.push_back(32'(4 * k));
        data_exp.push_back(32'hDEAD_BEEF);
        cyc(); mid();
        cyc(); mid();
        cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_func = 3'b010; mid();
        chk("p3_load_en", mem_en, 1);
        chk("p3_load_addr", mem_addr, 32'h40);
        chk("p3_load_we", mem_we, 0);
        chk("p3_c3_pc", inst_pc, 32'h8);
        cyc(); mid();
        chk("p3_done", d_done, 1);
        chk("p3_bubble", inst_valid, 0);
        cyc(); d_req = 1'b0; mid();
        chk("p3_resume_pc", inst_pc, 32'hC);
        cyc(); mid();
        cyc(); mid();
        cyc(); inst_ready = 1'b0;

        // Redirect with fetch of 0x10 in flight.
        cyc(); rst = 1'b1; mid();
        cyc(); rst = 1'b0; inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) inst_exp.push_back(32'(4 * k));
        for (int k = 0; k < 3; k++) inst_exp.push_back(32'h100 + 32'(4 * k));
        for (int k = 1; k <= 4; k++) begin
            cyc(); mid();
        end
        chk("p4_fetch10_addr", mem_addr, 32'h10);
        chk("p4_fetch10_en", mem_en, 1);
        cyc(); redirect = 1'b1; redirect_pc = 32'h103; mid();
        chk("p4_redir_no_issue", mem_en, 0);
        cyc(); redirect = 1'b0; mid();
        chk("p4_r1_valid", inst_valid, 0);
        chk("p4_r1_fetch_en", mem_en, 1);
        chk("p4_r1_fetch_addr", mem_addr, 32'h100);
        cyc(); mid();
        chk("p4_r2_valid", inst_valid, 1);
        chk("p4_r2_pc", inst_pc, 32'h100);
        cyc(); mid();
        cyc(); mid();
        cyc(); inst_ready = 1'b0;

        // Load sets d_rdata, byte store leaves it alone, reload sees the merged byte.
        dacc(1'b0, 3'b010, 32'h40, 32'h0, 32'hDEAD_BEEF);
        dacc(1'b1, 3'b000, 32'h20, 32'hAB, 32'hDEAD_BEEF);
        dacc(1'b0, 3'b010, 32'h20, 32'h0, 32'h0000_00AB);

        // Reset with full queue and a load in flight.
        cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_func = 3'b010; mid();
        chk("p6_load_en", mem_en, 1);
        cyc(); d_req = 1'b0; rst = 1'b1; mid();
        chk("p6_rst_mem_en", mem_en, 0);
        for (int k = 0; k < 3; k++) inst_exp.push_back(32'(4 * k));
        cyc(); rst = 1'b0; inst_ready = 1'b1; mid();
        chk("p6_valid", inst_valid, 0);
        chk("p6_d_done", d_done, 0);
        chk("p6_d_rdata", d_rdata, 32'h0);
        chk("p6_fetch_en", mem_en, 1);
        chk("p6_fetch_addr", mem_addr, 32'h0);
        cyc(); mid();
        chk("p6_first_pc", inst_pc, 32'h0);
        cyc();
        cyc();
        cyc(); inst_ready = 1'b0;
        for (int k = 0; k < 4; k++) cyc();

        chk("inst_queue_drained", 32'(inst_exp.size()), 32'h0);
        chk("data_queue_drained", 32'(data_exp.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
